jk_bank_ctrl: RTL and testbench
===============================

Name: jk_bank_ctrl

Overview:
Sequencing controller for a bank of WIDTH JK flip-flops sharing one CLK. It accepts commands over a valid/ready handshake and drives per-bit J/K vectors. Each step reads the bank's true outputs back, so the flops can be cleared, set, toggled, loaded, counted up or down, or shifted. It sits between control logic and the JK bank. The bank's PR/CLR pins are held inactive at integration and are not driven by this block.

Parameters:
WIDTH, 4, number of JK flip-flops in the controlled bank
CNT_W, 8, width of the repeat-count field

Ports:
CLK  input  1  clock; shared with the JK bank
CLR  input  1  synchronous active-high reset
CMD_VALID  input  1  command present
CMD_READY  output  1  controller can accept; combinational: (state==IDLE) & ~CLR
CMD_OP  input  3  0 NOP, 1 CLEAR, 2 SET, 3 TOGGLE, 4 LOAD, 5 COUNT_UP, 6 COUNT_DOWN, 7 SHIFT_LEFT
CMD_DATA  input  WIDTH  mask/value/serial-in operand
CMD_COUNT  input  CNT_W  step count for ops 5-7; 0 is treated as 1
Q_FB  input  WIDTH  bank true outputs (P pins)
J  output  WIDTH  registered J vector to bank
K  output  WIDTH  registered K vector to bank
BUSY  output  1  registered; high in DRIVE/SETTLE
DONE  output  1  registered one-cycle pulse at command completion
TC  output  1  registered sticky terminal-count flag

Behaviour:
- Reset: CLR sampled high at a CLK edge sets state=IDLE, J=0, K=0, BUSY=0, DONE=0, TC=0, remaining=0. This applies from any state. An in-flight command is abandoned with no DONE.
- States: IDLE, DRIVE, SETTLE. J=K=0 (hold) in every cycle except DRIVE.
- IDLE: at an edge with CMD_VALID&CMD_READY:
  - latch OP, DATA and remaining = max(COUNT,1) (ops 0-4 use 1);
  - compute the step vectors from the current Q_FB and register them into J/K;
  - go to DRIVE; BUSY=1; TC cleared.
- NOP registers J=K=0 and still completes normally.
- DRIVE: J/K are stable for exactly one cycle, and the bank updates at the closing edge. At that edge: J=K=0, remaining decremented, go to SETTLE.
- SETTLE: at the closing edge:
  - if remaining==0: go to IDLE, BUSY=0, DONE=1 for one cycle;
  - else: recompute J/K from the settled Q_FB and go to DRIVE.
  - TC sets when OP=COUNT_UP and Q_FB is all ones, or OP=COUNT_DOWN and Q_FB==0. TC stays set until the next accept or CLR.
- Step vectors, bit i:
  - CLEAR: J=0, K=1.
  - SET: J=1, K=0.
  - TOGGLE: J=K=DATA[i].
  - LOAD: J=DATA[i], K=~DATA[i].
  - COUNT_UP: J=K=&Q_FB[i-1:0]; bit 0 is always 1.
  - COUNT_DOWN: J=K=~|Q_FB[i-1:0]; bit 0 is always 1.
  - SHIFT_LEFT: t = Q_FB[i-1] (bit 0 uses DATA[0]); J=t, K=~t.
- Counting wraps modulo 2^WIDTH; it never saturates or stops early.
- Latency: accept edge E0 → J/K valid in cycle E0..E1 → Q_FB updated after E1. Each step costs 2 cycles, so BUSY lasts 2N cycles. DONE is high in the cycle after the final SETTLE edge. CMD_READY is high in that same cycle, so back-to-back commands need no bubble beyond SETTLE.
- CMD_VALID while not ready is ignored; there is no queuing. CMD_DATA/OP/COUNT are only sampled at accept.
- CLR and CMD_VALID in the same cycle: reset wins and the command is not accepted (CMD_READY=0).
- Changes to Q_FB during DRIVE (from the bank's own edge) must not alter the already-registered J/K.

Test Plan:
- Reset: CLR=1 for 2 cycles mid COUNT_UP → next cycle J=0000, K=0000, BUSY=0, DONE never pulses, CMD_READY=1 once CLR=0.
- LOAD DATA=1010 from Q_FB=0000 → J=1010, K=0101 for one cycle; Q_FB=1010; BUSY high 2 cycles; DONE pulse of exactly 1 cycle.
- COUNT_UP COUNT=3 from 1110 → Q_FB 1111, 0000, 0001; TC=1 at completion; BUSY high 6 cycles; single DONE.
- COUNT_DOWN COUNT=0 (treated as 1) from 0001 → 0000, TC=1. Repeat from 0000 → 1111 (wrap), TC=0.
- SHIFT_LEFT DATA[0]=1 COUNT=2 from 0100 → 1001 then 0011. CMD_VALID pulsed during BUSY is ignored and does not alter results.
- TOGGLE DATA=0110 on 1100, then CLEAR issued back-to-back at the DONE cycle → 1010 then 0000; second accept occurs in the DONE cycle.

Source files
------------

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: issues one J/K step per DRIVE cycle,
// then waits a SETTLE cycle so the next step is computed from the bank's settled outputs.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             BUSY,
  output logic             DONE,
  output logic             TC
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;

  localparam logic [2:0] OpNop      = 3'd0;
  localparam logic [2:0] OpClear    = 3'd1;
  localparam logic [2:0] OpSet      = 3'd2;
  localparam logic [2:0] OpToggle   = 3'd3;
  localparam logic [2:0] OpLoad     = 3'd4;
  localparam logic [2:0] OpCountUp  = 3'd5;
  localparam logic [2:0] OpCountDn  = 3'd6;
  localparam logic [2:0] OpShiftL   = 3'd7;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             busy_q, busy_d, done_q, done_d, tc_q, tc_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_data, step_j, step_k;
  logic             lower_all_ones, lower_all_zero, prev_bit;

  assign CMD_READY = (state_q == StIdle) & ~CLR;

  // While idle the step is built from the incoming command so J/K register at accept.
  assign step_op   = (state_q == StIdle) ? CMD_OP : op_q;
  assign step_data = (state_q == StIdle) ? CMD_DATA : data_q;

  always_comb begin
    step_j         = '0;
    step_k         = '0;
    lower_all_ones = 1'b1;
    lower_all_zero = 1'b1;
    prev_bit       = step_data[0];
    for (int i = 0; i < WIDTH; i++) begin
      unique case (step_op)
        OpNop:     begin step_j[i] = 1'b0;           step_k[i] = 1'b0;            end
        OpClear:   begin step_j[i] = 1'b0;           step_k[i] = 1'b1;            end
        OpSet:     begin step_j[i] = 1'b1;           step_k[i] = 1'b0;            end
        OpToggle:  begin step_j[i] = step_data[i];   step_k[i] = step_data[i];    end
        OpLoad:    begin step_j[i] = step_data[i];   step_k[i] = ~step_data[i];   end
        OpCountUp: begin step_j[i] = lower_all_ones; step_k[i] = lower_all_ones;  end
        OpCountDn: begin step_j[i] = lower_all_zero; step_k[i] = lower_all_zero;  end
        OpShiftL:  begin step_j[i] = prev_bit;       step_k[i] = ~prev_bit;       end
        default:   begin step_j[i] = 1'b0;           step_k[i] = 1'b0;            end
      endcase
      lower_all_ones = lower_all_ones & Q_FB[i];
      lower_all_zero = lower_all_zero & ~Q_FB[i];
      prev_bit       = Q_FB[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    j_d         = '0;
    k_d         = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tc_d        = tc_q;
    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          op_d        = CMD_OP;
          data_d      = CMD_DATA;
          remaining_d = (CMD_OP >= OpCountUp && CMD_COUNT != '0) ? CMD_COUNT : CNT_W'(1);
          j_d         = step_j;
          k_d         = step_k;
          busy_d      = 1'b1;
          tc_d        = 1'b0;
          state_d     = StDrive;
        end
      end
      StDrive: begin
        remaining_d = remaining_q - 1'b1;
        state_d     = StSettle;
      end
      StSettle: begin
        if ((op_q == OpCountUp && (&Q_FB)) || (op_q == OpCountDn && ~(|Q_FB))) tc_d = 1'b1;
        if (remaining_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          j_d     = step_j;
          k_d     = step_k;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= StIdle;
      op_q        <= OpNop;
      data_q      <= '0;
      remaining_q <= '0;
      j_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      j_q         <= j_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tc_q        <= tc_d;
    end
  end

  assign J    = j_q;
  assign K    = k_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign TC   = tc_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: a behavioural JK bank closes the loop, a scoreboard checks each DONE.
module tb_jk_bank_ctrl;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [2:0] CMD_OP = 3'd0;
  logic [3:0] CMD_DATA = 4'd0;
  logic [7:0] CMD_COUNT = 8'd0;
  logic [3:0] Q_FB;
  logic [3:0] J, K;
  logic       BUSY, DONE, TC;

  logic [3:0] bank_q = 4'd0;

  typedef struct {
    int         id;
    logic [3:0] j0;
    logic [3:0] k0;
    logic [3:0] q;
    logic       tc;
    int         busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_DATA  (CMD_DATA),
    .CMD_COUNT (CMD_COUNT),
    .Q_FB      (Q_FB),
    .J         (J),
    .K         (K),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .TC        (TC)
  );

  always #5 CLK = ~CLK;

  // JK bank: 00 hold, 01 reset, 10 set, 11 toggle.
  always @(posedge CLK) bank_q <= (J & ~bank_q) | (~K & bank_q);
  assign Q_FB = bank_q;

  task automatic chk(input string nm, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s (cmd %0d): got %0h, expected %0h", nm, id, act, req);
    end
  endtask

  logic [3:0] mon_j0 = 4'd0, mon_k0 = 4'd0;
  int         mon_busy = 0;
  logic       busy_prev = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    if (BUSY && !busy_prev) begin
      mon_j0   = J;
      mon_k0   = K;
      mon_busy = 0;
    end
    if (BUSY) mon_busy++;
    busy_prev = BUSY;
    if (DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", -1, 1, 0);
      end else begin
        e = sb.pop_front();
        chk("first_j", e.id, int'(mon_j0), int'(e.j0));
        chk("first_k", e.id, int'(mon_k0), int'(e.k0));
        chk("final_q", e.id, int'(Q_FB), int'(e.q));
        chk("tc", e.id, int'(TC), int'(e.tc));
        chk("busy_cycles", e.id, mon_busy, e.busy);
      end
    end
  end

  task automatic send(input int id, input logic [2:0] op, input logic [3:0] d,
                      input logic [7:0] c, input logic [3:0] j0, input logic [3:0] k0,
                      input logic [3:0] q, input logic tc, input int busy,
                      output logic acc_in_done);
    exp_t e;
    int   n;
    acc_in_done = 1'b0;
    @(negedge CLK);
    CMD_OP    = op;
    CMD_DATA  = d;
    CMD_COUNT = c;
    CMD_VALID = 1'b1;
    n = 0;
    while (!CMD_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_READY) begin
      chk("accept_timeout", id, 0, 1);
      CMD_VALID = 1'b0;
      return;
    end
    acc_in_done = DONE;
    e.id = id; e.j0 = j0; e.k0 = k0; e.q = q; e.tc = tc; e.busy = busy;
    sb.push_back(e);
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  initial begin
    logic ad;
    int   n;
    // Reset state, with a command offered during reset.
    CMD_VALID = 1'b1;
    CMD_OP    = 3'd2;
    #1 chk("ready_in_clr", 0, int'(CMD_READY), 0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_j", 0, int'(J), 0);
    chk("rst_k", 0, int'(K), 0);
    chk("rst_busy", 0, int'(BUSY), 0);
    chk("rst_done", 0, int'(DONE), 0);
    chk("rst_tc", 0, int'(TC), 0);
    chk("rst_bank_untouched", 0, int'(Q_FB), 0);
    CLR = 1'b0;
    CMD_VALID = 1'b0;
    #1 chk("ready_after_clr", 0, int'(CMD_READY), 1);

    //   id  op    data     cnt    j0       k0       q        tc    busy
    send(1,  3'd4, 4'b1010, 8'd0, 4'b1010, 4'b0101, 4'b1010, 1'b0, 2, ad);

    // Long COUNT_UP abandoned by a 2-cycle CLR: no DONE may follow.
    send(99, 3'd5, 4'b0000, 8'd10, 4'b0001, 4'b0001, 4'b0000, 1'b0, 20, ad);
    repeat (3) @(negedge CLK);
    CLR = 1'b1;
    CMD_VALID = 1'b1;
    #1 chk("ready_clr_vs_valid", 99, int'(CMD_READY), 0);
    @(negedge CLK);
    chk("midrst_j", 99, int'(J), 0);
    chk("midrst_k", 99, int'(K), 0);
    chk("midrst_busy", 99, int'(BUSY), 0);
    @(negedge CLK);
    chk("midrst_busy2", 99, int'(BUSY), 0);
    sb.delete();
    CLR = 1'b0;
    CMD_VALID = 1'b0;
    #1 chk("ready_after_midrst", 99, int'(CMD_READY), 1);
    repeat (4) @(negedge CLK);

    send(2,  3'd4, 4'b1110, 8'd0, 4'b1110, 4'b0001, 4'b1110, 1'b0, 2, ad);
    send(3,  3'd5, 4'b0000, 8'd3, 4'b0001, 4'b0001, 4'b0001, 1'b1, 6, ad);
    send(4,  3'd6, 4'b0000, 8'd0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2, ad);
    send(5,  3'd6, 4'b0000, 8'd0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2, ad);
    send(6,  3'd4, 4'b0100, 8'd0, 4'b0100, 4'b1011, 4'b0100, 1'b0, 2, ad);
    send(7,  3'd7, 4'b0001, 8'd2, 4'b1001, 4'b0110, 4'b0011, 1'b0, 4, ad);
    // Command offered while busy must be ignored.
    @(negedge CLK);
    CMD_OP    = 3'd1;
    CMD_DATA  = 4'b1111;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    chk("ready_while_busy", 7, int'(CMD_READY), 0);
    CMD_VALID = 1'b0;

    send(8,  3'd4, 4'b1100, 8'd0, 4'b1100, 4'b0011, 4'b1100, 1'b0, 2, ad);
    send(9,  3'd3, 4'b0110, 8'd0, 4'b0110, 4'b0110, 4'b1010, 1'b0, 2, ad);
    send(10, 3'd1, 4'b0000, 8'd0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2, ad);
    chk("b2b_accept_in_done", 10, int'(ad), 1);
    send(11, 3'd2, 4'b0000, 8'd0, 4'b1111, 4'b0000, 4'b1111, 1'b0, 2, ad);
    send(12, 3'd5, 4'b0000, 8'd0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2, ad);
    send(13, 3'd0, 4'b1111, 8'd5, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2, ad);

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", -1, sb.size(), 0);
    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
